// File: rtl/mem_copy_engine.sv
// Word-serial memory-to-memory copy engine sharing one address port for reads and writes.
// Each word takes a READ cycle (latch into Hold) followed by a WRITE cycle.
module mem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  output logic [A-1:0] MemAddr,
  output logic         MemWriteEn,
  output logic [W-1:0] MemDataOut,
  input  logic [W-1:0] MemDataIn,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A-1:0] len_q, len_d;
  logic [W-1:0] hold_q, hold_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
    end
  end

  // Parameters are only captured in IDLE, so Start while busy cannot disturb them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          len_d   = Len;
          cnt_d   = '0;
          state_d = (Len != '0) ? READ : DONE;
        end
      end
      READ: begin
        hold_d  = MemDataIn;
        state_d = WRITE;
      end
      WRITE: begin
        if (cnt_q == len_q - A'(1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + A'(1);
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state; address sums wrap modulo 2**A.
  always_comb begin
    MemAddr    = '0;
    MemWriteEn = 1'b0;
    MemDataOut = hold_q;
    Busy       = (state_q != IDLE);
    Done       = (state_q == DONE);
    case (state_q)
      READ:  MemAddr = src_q + cnt_q;
      WRITE: begin
        MemAddr    = dst_q + cnt_q;
        MemWriteEn = 1'b1;
      end
      default: MemAddr = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine, with a behavioural 256-word memory
// attached to the shared address port.
module tb_mem_copy_engine;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic [7:0] SrcAddr;
   logic [7:0] DstAddr;
   logic [7:0] Len;
   logic [7:0] MemAddr;
   logic       MemWriteEn;
   logic [7:0] MemDataOut;
   logic [7:0] MemDataIn;
   logic       Busy;
   logic       Done;

   logic [7:0] mem [0:255];
   logic       loadEn;
   logic [7:0] loadAddr;
   logic [7:0] loadData;

   int checks = 0;
   int errors = 0;

   mem_copy_engine #(.W(8), .A(8)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .SrcAddr   (SrcAddr),
      .DstAddr   (DstAddr),
      .Len       (Len),
      .MemAddr   (MemAddr),
      .MemWriteEn(MemWriteEn),
      .MemDataOut(MemDataOut),
      .MemDataIn (MemDataIn),
      .Busy      (Busy),
      .Done      (Done)
   );

   // Free-running 10 ns clock; rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Memory model: combinational read, write on the rising edge; the bench preloads
   // words through the same process so the array has a single writer.
   assign MemDataIn = mem[MemAddr];

   always @(posedge Clk) begin
      if (MemWriteEn)
         mem[MemAddr] <= MemDataOut;
      else if (loadEn)
         mem[loadAddr] <= loadData;
   end

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Preloads one memory word while the engine is not writing.
   task automatic loadWord(input logic [7:0] a, input logic [7:0] d);
      loadAddr = a;
      loadData = d;
      loadEn   = 1'b1;
      @(posedge Clk);
      #1;
      loadEn   = 1'b0;
   endtask

   // Issues one copy request and follows it cycle by cycle: alternating READ/WRITE
   // addresses, write data equal to the word just read, Done exactly 2*len cycles
   // after the Start edge, then idle. pokeAt>=0 re-asserts Start with other
   // parameters during that cycle of the copy, which must be ignored.
   task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst,
                                input logic [7:0] len, input int pokeAt);
      logic [7:0] rdAddr;
      logic [7:0] wrAddr;
      logic [7:0] expData;
      expData = 8'h00;
      SrcAddr = src;
      DstAddr = dst;
      Len     = len;
      Start   = 1'b1;
      @(posedge Clk);
      #1;
      Start   = 1'b0;
      SrcAddr = 8'h33;
      DstAddr = 8'h77;
      Len     = 8'h02;
      for (int i = 0; i < 2 * int'(len); i++) begin
         if (i == pokeAt) begin
            Start   = 1'b1;
            SrcAddr = 8'h40;
            DstAddr = 8'h44;
            Len     = 8'h01;
         end else begin
            Start   = 1'b0;
         end
         checkOutput("busy_during_copy", 32'(Busy), 32'd1);
         checkOutput("done_during_copy", 32'(Done), 32'd0);
         if (i % 2 == 0) begin
            rdAddr  = src + 8'(i / 2);
            expData = mem[rdAddr];
            checkOutput("read_addr", 32'(MemAddr), 32'(rdAddr));
            checkOutput("read_we", 32'(MemWriteEn), 32'd0);
         end else begin
            wrAddr = dst + 8'(i / 2);
            checkOutput("write_addr", 32'(MemAddr), 32'(wrAddr));
            checkOutput("write_we", 32'(MemWriteEn), 32'd1);
            checkOutput("write_data", 32'(MemDataOut), 32'(expData));
         end
         @(posedge Clk);
         #1;
      end
      Start = 1'b0;
      checkOutput("done_pulse", 32'(Done), 32'd1);
      checkOutput("busy_in_done", 32'(Busy), 32'd1);
      checkOutput("we_in_done", 32'(MemWriteEn), 32'd0);
      checkOutput("addr_in_done", 32'(MemAddr), 32'd0);
      @(posedge Clk);
      #1;
      checkOutput("done_cleared", 32'(Done), 32'd0);
      checkOutput("busy_cleared", 32'(Busy), 32'd0);
   endtask

   // Directed sequence: reset, preload, then each copy scenario in turn.
   initial begin
      Reset    = 1'b1;
      Start    = 1'b0;
      SrcAddr  = 8'h00;
      DstAddr  = 8'h00;
      Len      = 8'h00;
      loadEn   = 1'b0;
      loadAddr = 8'h00;
      loadData = 8'h00;
      #2;
      checkOutput("rst_busy", 32'(Busy), 32'd0);
      checkOutput("rst_done", 32'(Done), 32'd0);
      checkOutput("rst_we", 32'(MemWriteEn), 32'd0);
      checkOutput("rst_addr", 32'(MemAddr), 32'd0);
      checkOutput("rst_dout", 32'(MemDataOut), 32'd0);

      loadWord(8'h10, 8'h61);
      loadWord(8'h11, 8'h62);
      loadWord(8'h12, 8'h63);
      loadWord(8'h13, 8'h64);
      loadWord(8'hFE, 8'hA1);
      loadWord(8'hFF, 8'hA2);
      loadWord(8'h00, 8'hA3);
      loadWord(8'h02, 8'h00);
      loadWord(8'h03, 8'h00);
      loadWord(8'h04, 8'h00);
      loadWord(8'h20, 8'h55);
      loadWord(8'h21, 8'h00);
      loadWord(8'h22, 8'h00);
      loadWord(8'h23, 8'h00);
      loadWord(8'h44, 8'h00);
      loadWord(8'h91, 8'hEE);

      Reset = 1'b0;
      @(posedge Clk);
      #1;
      checkOutput("idle_busy", 32'(Busy), 32'd0);
      checkOutput("idle_we", 32'(MemWriteEn), 32'd0);

      // Basic four-word copy.
      applyStimulus(8'h10, 8'h80, 8'd4, -1);
      checkOutput("mem80", 32'(mem[8'h80]), 32'h61);
      checkOutput("mem81", 32'(mem[8'h81]), 32'h62);
      checkOutput("mem82", 32'(mem[8'h82]), 32'h63);
      checkOutput("mem83", 32'(mem[8'h83]), 32'h64);

      // Zero-length request: Done right after the Start edge, nothing written.
      applyStimulus(8'h10, 8'h80, 8'd0, -1);
      checkOutput("len0_mem80", 32'(mem[8'h80]), 32'h61);

      // Source wraps past 0xFF.
      applyStimulus(8'hFE, 8'h02, 8'd3, -1);
      checkOutput("wrap_mem02", 32'(mem[8'h02]), 32'hA1);
      checkOutput("wrap_mem03", 32'(mem[8'h03]), 32'hA2);
      checkOutput("wrap_mem04", 32'(mem[8'h04]), 32'hA3);

      // Start while busy is ignored; the next copy goes straight after Done.
      applyStimulus(8'h10, 8'h84, 8'd4, 3);
      applyStimulus(8'h20, 8'h21, 8'd3, -1);
      checkOutput("busy_mem84", 32'(mem[8'h84]), 32'h61);
      checkOutput("busy_mem87", 32'(mem[8'h87]), 32'h64);
      checkOutput("busy_mem44", 32'(mem[8'h44]), 32'h00);
      checkOutput("ovl_mem21", 32'(mem[8'h21]), 32'h55);
      checkOutput("ovl_mem22", 32'(mem[8'h22]), 32'h55);
      checkOutput("ovl_mem23", 32'(mem[8'h23]), 32'h55);

      // Reset in the middle of the second WRITE cycle aborts the copy.
      SrcAddr = 8'h10;
      DstAddr = 8'h90;
      Len     = 8'd4;
      Start   = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      @(posedge Clk);
      #1;
      checkOutput("abort_w0_addr", 32'(MemAddr), 32'h90);
      @(posedge Clk);
      #1;
      @(posedge Clk);
      #1;
      checkOutput("abort_w1_we", 32'(MemWriteEn), 32'd1);
      checkOutput("abort_w1_addr", 32'(MemAddr), 32'h91);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("abort_we", 32'(MemWriteEn), 32'd0);
      checkOutput("abort_busy", 32'(Busy), 32'd0);
      checkOutput("abort_done", 32'(Done), 32'd0);
      checkOutput("abort_addr", 32'(MemAddr), 32'd0);
      checkOutput("abort_dout", 32'(MemDataOut), 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge Clk);
         #1;
         checkOutput("post_abort_done", 32'(Done), 32'd0);
         checkOutput("post_abort_busy", 32'(Busy), 32'd0);
      end
      checkOutput("abort_mem90", 32'(mem[8'h90]), 32'h61);
      checkOutput("abort_mem91", 32'(mem[8'h91]), 32'hEE);

      // First Start after reset release is accepted.
      applyStimulus(8'h12, 8'hA0, 8'd1, -1);
      checkOutput("after_rst_memA0", 32'(mem[8'hA0]), 32'h63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
